vec_seq: RTL and testbench

Parametrised, self-checking stimulus sequencer for combinational lab circuits. It walks every WIDTH-bit input vector, holds each vector for a programmable number of clock cycles, and compares the DUT's single-bit output against a supplied truth table. It counts mismatches and records the first failing vector. It sits between a DUT's inputs/output and the bench or board-level status logic.

---
 rtl/vec_seq.sv | 133 +++++++++++++
 tb/tb_vec_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_seq.sv
`default_nettype none
// ============================================================================
// Module   : vec_seq
// Purpose  : Walks every WIDTH-bit vector into a combinational DUT, holds each
//            for HOLD cycles and checks the DUT output against a truth table.
// Option   : VEC_SEQ_GRAY_EN selects Gray-code vector order instead of binary.
// Revision : 1.0 - initial release
// ============================================================================
module vec_seq #(
  parameter int WIDTH = 4,
  parameter int HOLD  = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [(1<<WIDTH)-1:0]  exp_tbl,
  input  logic [(1<<WIDTH)-1:0]  skip,
  input  logic                   dut_x,
  output logic [WIDTH-1:0]       vec_out,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH:0]         err_cnt,
  output logic                   err_flag,
  output logic [WIDTH-1:0]       first_err
);

  localparam int                 c_n         = 1 << WIDTH;
  localparam int                 c_hw        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [c_hw-1:0]    c_hold_last = c_hw'(HOLD - 1);
  localparam logic [WIDTH-1:0]   c_idx_last  = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]     c_err_max   = (WIDTH+1)'(c_n);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_idx;
  logic [c_hw-1:0]   r_hold;
  logic [WIDTH-1:0]  r_vec;
  logic [WIDTH:0]    r_err_cnt;
  logic              r_err_flag;
  logic [WIDTH-1:0]  r_first_err;

  logic [WIDTH-1:0]  w_cur;
  logic [WIDTH-1:0]  w_next_idx;
  logic [WIDTH-1:0]  w_next_vec;
  logic              w_in_drive;
  logic              w_cur_skip;
  logic              w_last_hold;
  logic              w_step;
  logic              w_miss;
  logic              w_start;

  // Sequence position to driven vector value.
  function automatic logic [WIDTH-1:0] map_idx(input logic [WIDTH-1:0] i);
`ifdef VEC_SEQ_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  assign w_cur       = map_idx(r_idx);
  assign w_next_idx  = r_idx + 1'b1;
  assign w_next_vec  = map_idx(w_next_idx);
  assign w_in_drive  = (r_state == DRIVE);
  assign w_cur_skip  = skip[w_cur];
  assign w_last_hold = (r_hold == c_hold_last);
  assign w_step      = w_in_drive && (w_cur_skip || w_last_hold);
  assign w_miss      = w_in_drive && !w_cur_skip && w_last_hold && (dut_x != exp_tbl[w_cur]);
  assign w_start     = start && !w_in_drive;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_nxt = DRIVE;
      DRIVE:      if (w_step && (r_idx == c_idx_last)) w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_hold      <= '0;
      r_vec       <= '0;
      r_err_cnt   <= '0;
      r_err_flag  <= 1'b0;
      r_first_err <= '0;
    end else if (w_start) begin
      r_idx       <= '0;
      r_hold      <= '0;
      r_vec       <= map_idx('0);
      r_err_cnt   <= '0;
      r_err_flag  <= 1'b0;
      r_first_err <= '0;
    end else if (w_in_drive) begin
      if (w_step) begin
        r_hold <= '0;
        r_idx  <= w_next_idx;
        // A skipped next vector keeps the previous value on the DUT pins.
        if ((r_idx != c_idx_last) && !skip[w_next_vec]) r_vec <= w_next_vec;
      end else begin
        r_hold <= r_hold + 1'b1;
      end
      if (w_miss) begin
        if (r_err_cnt != c_err_max) r_err_cnt <= r_err_cnt + 1'b1;
        if (!r_err_flag) begin
          r_err_flag  <= 1'b1;
          r_first_err <= w_cur;
        end
      end
    end
  end

  assign vec_out   = r_vec;
  assign busy      = w_in_drive;
  assign done      = (r_state == DONE);
  assign err_cnt   = r_err_cnt;
  assign err_flag  = r_err_flag;
  assign first_err = r_first_err;

endmodule
`default_nettype wire

// File: tb/tb_vec_seq.sv
`default_nettype none
// Directed self-checking bench for vec_seq (WIDTH=4, HOLD=10) with a
// behavioural DUT whose output can be inverted per driven vector value.
`timescale 1ns/1ps
module tb_vec_seq;
  localparam int WIDTH = 4;
  localparam int HOLD  = 10;
  localparam int N     = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [N-1:0]     exp_tbl = 16'hA5C3;
  logic [N-1:0]     skip = '0;
  logic [N-1:0]     inv = '0;
  logic             dut_x;
  logic [WIDTH-1:0] vec_out, first_err;
  logic             busy, done, err_flag;
  logic [WIDTH:0]   err_cnt;

  int n_vec = 0;
  int n_err = 0;
  int busy_cnt;
  logic [WIDTH-1:0] seq[$];
  int runlen[$];
  logic [WIDTH-1:0] first_vec;
  logic first_busy;

  vec_seq #(.WIDTH(WIDTH), .HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_tbl(exp_tbl), .skip(skip),
    .dut_x(dut_x), .vec_out(vec_out), .busy(busy), .done(done),
    .err_cnt(err_cnt), .err_flag(err_flag), .first_err(first_err)
  );

  always #5 clk = ~clk;

  // Behavioural lab circuit: truth table, optionally corrupted per vector.
  assign dut_x = exp_tbl[vec_out] ^ inv[vec_out];

  function automatic logic [WIDTH-1:0] bmap(input int i);
    logic [WIDTH-1:0] v;
    v = WIDTH'(i);
`ifdef VEC_SEQ_GRAY_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    first_vec  = vec_out;
    first_busy = busy;
  endtask

  // Observes the run until done (bounded); optionally re-pulses start mid-run.
  task automatic run_to_done(input int mid_start);
    int cyc;
    seq.delete();
    runlen.delete();
    busy_cnt = 0;
    cyc = 0;
    while (!done && cyc <= 1000) begin
      if (busy) begin
        busy_cnt++;
        if (seq.size() == 0 || vec_out != seq[seq.size()-1]) begin
          seq.push_back(vec_out);
          runlen.push_back(1);
        end else begin
          runlen[runlen.size()-1] = runlen[runlen.size()-1] + 1;
        end
      end
      start = (cyc == mid_start);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_vec++;
    if ({vec_out, busy, done, err_cnt, err_flag, first_err} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got vec=%h busy=%b done=%b cnt=%0d flag=%b first=%h, want all 0",
               vec_out, busy, done, err_cnt, err_flag, first_err);
    end
  endtask

  task automatic test_clean_pass();
    bit seq_ok, len_ok;
    exp_tbl = 16'hA5C3; skip = '0; inv = '0;
    pulse_start();
    n_vec++;
    if (first_busy !== 1'b1 || first_vec !== bmap(0)) begin
      n_err++;
      $display("FAIL start_latency: got busy=%b vec=%h, want busy=1 vec=%h", first_busy, first_vec, bmap(0));
    end
    run_to_done(-1);
    seq_ok = (seq.size() == N);
    len_ok = (runlen.size() == N);
    for (int i = 0; i < N && seq_ok; i++) if (seq[i] !== bmap(i)) seq_ok = 1'b0;
    for (int i = 0; i < N && len_ok; i++) if (runlen[i] != HOLD) len_ok = 1'b0;
    n_vec++;
    if (!seq_ok) begin
      n_err++;
      $display("FAIL clean_sequence: got %0d distinct steps in wrong order, want %0d in map order", seq.size(), N);
    end
    n_vec++;
    if (!len_ok) begin
      n_err++;
      $display("FAIL clean_hold: some vector not held exactly %0d cycles (%0d runs)", HOLD, runlen.size());
    end
    n_vec++;
    if (busy_cnt != 160 || done !== 1'b1) begin
      n_err++;
      $display("FAIL clean_length: got busy=%0d done=%b, want busy=160 done=1", busy_cnt, done);
    end
    n_vec++;
    if (err_cnt !== 5'd0 || err_flag !== 1'b0 || vec_out !== bmap(N-1) || busy !== 1'b0) begin
      n_err++;
      $display("FAIL clean_result: got cnt=%0d flag=%b vec=%h busy=%b, want cnt=0 flag=0 vec=%h busy=0",
               err_cnt, err_flag, vec_out, busy, bmap(N-1));
    end
`ifdef VEC_SEQ_GRAY_EN
    begin
      bit ham_ok;
      ham_ok = (seq.size() == N);
      for (int i = 0; i + 1 < seq.size(); i++) if ($countones(seq[i] ^ seq[i+1]) != 1) ham_ok = 1'b0;
      n_vec++;
      if (!ham_ok) begin
        n_err++;
        $display("FAIL gray_hamming: consecutive vectors differ by more than one bit");
      end
    end
`endif
  endtask

  task automatic test_mismatch();
    skip = '0; inv = 16'h0208;
    pulse_start();
    run_to_done(-1);
    n_vec++;
    if (err_cnt !== 5'd2 || err_flag !== 1'b1 || first_err !== 4'd3 || done !== 1'b1) begin
      n_err++;
      $display("FAIL mismatch: got cnt=%0d flag=%b first=%h done=%b, want cnt=2 flag=1 first=3 done=1",
               err_cnt, err_flag, first_err, done);
    end
  endtask

  task automatic test_start_in_done();
    inv = '0;
    pulse_start();
    n_vec++;
    if (err_cnt !== 5'd0 || err_flag !== 1'b0 || first_err !== 4'd0 || busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL restart_clear: got cnt=%0d flag=%b first=%h busy=%b done=%b, want 0 0 0 1 0",
               err_cnt, err_flag, first_err, busy, done);
    end
    run_to_done(-1);
    n_vec++;
    if (busy_cnt != 160 || err_cnt !== 5'd0 || done !== 1'b1) begin
      n_err++;
      $display("FAIL restart_run: got busy=%0d cnt=%0d done=%b, want 160 0 1", busy_cnt, err_cnt, done);
    end
  endtask

  task automatic test_skip();
    bit saw6;
    skip = 16'h0040; inv = '0;
    pulse_start();
    run_to_done(-1);
    saw6 = 1'b0;
    foreach (seq[i]) if (seq[i] == 4'd6) saw6 = 1'b1;
    n_vec++;
    if (saw6 || seq.size() != 15) begin
      n_err++;
      $display("FAIL skip_sequence: got saw6=%b steps=%0d, want saw6=0 steps=15", saw6, seq.size());
    end
    n_vec++;
    if (busy_cnt != 151 || err_cnt !== 5'd0 || done !== 1'b1) begin
      n_err++;
      $display("FAIL skip_length: got busy=%0d cnt=%0d done=%b, want 151 0 1", busy_cnt, err_cnt, done);
    end
  endtask

  task automatic test_all_skip();
    skip = 16'hFFFF; inv = 16'hFFFF;
    pulse_start();
    run_to_done(-1);
    n_vec++;
    if (busy_cnt != 16 || err_cnt !== 5'd0 || err_flag !== 1'b0 || done !== 1'b1) begin
      n_err++;
      $display("FAIL all_skip: got busy=%0d cnt=%0d flag=%b done=%b, want 16 0 0 1", busy_cnt, err_cnt, err_flag, done);
    end
    skip = '0; inv = '0;
  endtask

  task automatic test_busy_start();
    pulse_start();
    run_to_done(50);
    n_vec++;
    if (busy_cnt != 160 || seq.size() != N || done !== 1'b1) begin
      n_err++;
      $display("FAIL busy_start: got busy=%0d steps=%0d done=%b, want 160 16 1", busy_cnt, seq.size(), done);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    pulse_start();
    cyc = 0;
    while (vec_out != 4'd5 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    n_vec++;
    if (cyc >= 300 || {vec_out, busy, done, err_cnt, err_flag, first_err} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got vec=%h busy=%b done=%b cnt=%0d (waited %0d), want all 0",
               vec_out, busy, done, err_cnt, cyc);
    end
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
    pulse_start();
    run_to_done(-1);
    n_vec++;
    if (busy_cnt != 160 || err_cnt !== 5'd0 || done !== 1'b1) begin
      n_err++;
      $display("FAIL reset_rerun: got busy=%0d cnt=%0d done=%b, want 160 0 1", busy_cnt, err_cnt, done);
    end
  endtask

  initial begin
    test_reset();
    test_clean_pass();
    test_mismatch();
    test_start_in_done();
    test_skip();
    test_all_skip();
    test_busy_start();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
